// File: rtl/mux4_rr_scheduler_pkg.sv
// Shared types and helpers for the four-source round-robin mux scheduler.
//   state_t   : scheduler FSM states (IDLE, SETTLE, XFER)
//   SEL_I0..3 : mux select encodings for {S1,S0}
//   onehot4   : converts a 2-bit select into a one-hot grant vector
package mux4_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        XFER   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_I0 = 2'b00;
    localparam logic [1:0] SEL_I1 = 2'b01;
    localparam logic [1:0] SEL_I2 = 2'b10;
    localparam logic [1:0] SEL_I3 = 2'b11;

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/mux4_rr_scheduler_if.sv
// Bus bundle between the four requesters/downstream sink and the scheduler.
//   req[3:0]      : request per source (bit n -> In)
//   I0..I3        : source data, DATA_W bits each
//   out_ready     : downstream ready
//   S1, S0        : registered mux select
//   gnt[3:0]      : registered one-hot grant
//   out_valid, Y  : output beat and its data (Y is 0 when not valid)
// Modports: master = requester/sink side, slave = scheduler side.
interface mux4_sched_if #(
    parameter int DATA_W = 1
);
    logic [3:0]        req;
    logic [DATA_W-1:0] I0;
    logic [DATA_W-1:0] I1;
    logic [DATA_W-1:0] I2;
    logic [DATA_W-1:0] I3;
    logic              out_ready;
    logic              S1;
    logic              S0;
    logic [3:0]        gnt;
    logic              out_valid;
    logic [DATA_W-1:0] Y;

    modport master (
        output req, I0, I1, I2, I3, out_ready,
        input  S1, S0, gnt, out_valid, Y
    );

    modport slave (
        input  req, I0, I1, I2, I3, out_ready,
        output S1, S0, gnt, out_valid, Y
    );
endinterface

// File: rtl/mux4_rr_scheduler_mux4_df.sv
// Single-bit 4:1 dataflow multiplexer.
//   I0..I3 : data inputs
//   S1, S0 : select, {S1,S0}=n picks In
//   Y      : selected bit
module mux4_df (
    input  logic I0,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic S1,
    input  logic S0,
    output logic Y
);
    assign Y = (~S1 & ~S0 & I0) |
               (~S1 &  S0 & I1) |
               ( S1 & ~S0 & I2) |
               ( S1 &  S0 & I3);
endmodule

// File: rtl/mux4_rr_scheduler_rr_pick4.sv
// Combinational rotating-priority picker for four requesters.
//   req[3:0] : request vector
//   ptr[1:0] : highest-priority index this round
//   any      : at least one request is set
//   idx[1:0] : first set request found searching ptr, ptr+1, ... mod 4
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] idx
);
    logic [1:0] cand;

    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        // Walk from the farthest offset back to ptr so the closest hit wins.
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler sharing one 4:1 mux datapath between four sources.
// Arbitrates req, drives the registered mux select {S1,S0} and one-hot gnt,
// and streams the granted source's data out through valid/ready for up to
// BURST beats per grant.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mux4_sched_if slave (req, I0..I3, out_ready in;
//              S1, S0, gnt, out_valid, Y out)
module mux4_rr_scheduler
    import mux4_sched_pkg::*;
#(
    parameter int DATA_W = 1,
    parameter int BURST  = 4
) (
    input  logic        clk,
    input  logic        rst,
    mux4_sched_if.slave bus
);
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

    state_t            state;
    logic [1:0]        ptr;
    logic [1:0]        sel;
    logic [3:0]        gnt_r;
    logic              vld;
    logic [CNT_W-1:0]  beat_cnt;

    logic              any;
    logic [1:0]        idx;
    logic              beat;
    logic [DATA_W-1:0] mux_y;

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr),
        .any (any),
        .idx (idx)
    );

    assign beat = vld & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            sel      <= SEL_I0;
            gnt_r    <= 4'b0000;
            vld      <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        sel      <= idx;
                        gnt_r    <= onehot4(idx);
                        beat_cnt <= '0;
                        state    <= SETTLE;
                    end else begin
                        // Selects keep their last value while idle.
                        gnt_r <= 4'b0000;
                    end
                end
                SETTLE: begin
                    // Select lines have had a full cycle to settle.
                    vld   <= 1'b1;
                    state <= XFER;
                end
                XFER: begin
                    if (beat) begin
                        // A dropped request still gets the beat that was on offer.
                        if (!bus.req[sel] || beat_cnt == LAST_BEAT) begin
                            gnt_r <= 4'b0000;
                            vld   <= 1'b0;
                            ptr   <= sel + 2'd1;
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    gnt_r <= 4'b0000;
                    vld   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        mux4_df u_mux (
            .I0 (bus.I0[b]),
            .I1 (bus.I1[b]),
            .I2 (bus.I2[b]),
            .I3 (bus.I3[b]),
            .S1 (sel[1]),
            .S0 (sel[0]),
            .Y  (mux_y[b])
        );
    end

    assign bus.S1        = sel[1];
    assign bus.S0        = sel[0];
    assign bus.gnt       = gnt_r;
    assign bus.out_valid = vld;
    // Zero-gate after the mux so Y never leaks a source while idle.
    assign bus.Y         = vld ? mux_y : '0;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler. Three instances cover the
// configurations exercised: a (DATA_W=1, BURST=4), b (DATA_W=1, BURST=1),
// c (DATA_W=8, BURST=2). Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_mux4_rr_scheduler;

    logic clk;
    logic rst;

    int total;
    int bad;

    mux4_sched_if #(.DATA_W(1)) bus_a ();
    mux4_sched_if #(.DATA_W(1)) bus_b ();
    mux4_sched_if #(.DATA_W(8)) bus_c ();

    mux4_rr_scheduler #(.DATA_W(1), .BURST(4)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
    mux4_rr_scheduler #(.DATA_W(1), .BURST(1)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
    mux4_rr_scheduler #(.DATA_W(8), .BURST(2)) u_c (.clk(clk), .rst(rst), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] dat_c [4];
    logic       dat_b [4];

    initial begin
        total = 0;
        bad   = 0;
        dat_c = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        dat_b = '{1'b1, 1'b0, 1'b1, 1'b0};

        bus_a.req = 4'b0000; bus_a.out_ready = 1'b0;
        bus_a.I0 = '0; bus_a.I1 = '0; bus_a.I2 = '0; bus_a.I3 = '0;
        bus_b.req = 4'b0000; bus_b.out_ready = 1'b0;
        bus_b.I0 = '0; bus_b.I1 = '0; bus_b.I2 = '0; bus_b.I3 = '0;
        bus_c.req = 4'b0000; bus_c.out_ready = 1'b0;
        bus_c.I0 = '0; bus_c.I1 = '0; bus_c.I2 = '0; bus_c.I3 = '0;

        rst = 1'b0;
        #1 rst = 1'b1;
        step();
        step();
        chk("rst_gnt",   32'(bus_a.gnt), 32'h0);
        chk("rst_sel",   32'({bus_a.S1, bus_a.S0}), 32'h0);
        chk("rst_valid", 32'(bus_a.out_valid), 32'h0);
        chk("rst_y",     32'(bus_a.Y), 32'h0);
        chk("rst_ptr",   32'(u_a.ptr), 32'h0);
        rst = 1'b0;
        step();

        // ---- single source, four-beat burst (a) ----
        bus_a.req = 4'b0001; bus_a.I0 = 1'b1; bus_a.out_ready = 1'b1;
        step();
        chk("t1_gnt", 32'(bus_a.gnt), 32'h1);
        chk("t1_sel", 32'({bus_a.S1, bus_a.S0}), 32'h0);
        chk("t1_vld_settle", 32'(bus_a.out_valid), 32'h0);
        step();
        chk("t1_vld", 32'(bus_a.out_valid), 32'h1);
        chk("t1_y",   32'(bus_a.Y), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_vld_burst", 32'(bus_a.out_valid), 32'h1);
            chk("t1_gnt_burst", 32'(bus_a.gnt), 32'h1);
        end
        step();
        chk("t1_vld_end", 32'(bus_a.out_valid), 32'h0);
        chk("t1_gnt_end", 32'(bus_a.gnt), 32'h0);
        chk("t1_y_end",   32'(bus_a.Y), 32'h0);
        chk("t1_ptr",     32'(u_a.ptr), 32'h1);
        bus_a.req = 4'b0000; bus_a.I0 = 1'b0;

        // ---- all four requesting, BURST=1 rotation (b) ----
        bus_b.I0 = dat_b[0]; bus_b.I1 = dat_b[1]; bus_b.I2 = dat_b[2]; bus_b.I3 = dat_b[3];
        bus_b.req = 4'b1111; bus_b.out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t2_gnt", 32'(bus_b.gnt), 32'h1 << (n % 4));
            chk("t2_sel", 32'({bus_b.S1, bus_b.S0}), 32'(n % 4));
            chk("t2_vld_idle", 32'(bus_b.out_valid), 32'h0);
            step();
            chk("t2_vld", 32'(bus_b.out_valid), 32'h1);
            chk("t2_y",   32'(bus_b.Y), 32'(dat_b[n % 4]));
            step();
            chk("t2_vld_gap", 32'(bus_b.out_valid), 32'h0);
            chk("t2_gnt_gap", 32'(bus_b.gnt), 32'h0);
        end
        bus_b.req = 4'b0000;

        // ---- source 2 stalled while its request drops (a, ptr=1) ----
        bus_a.req = 4'b0100; bus_a.I2 = 1'b1; bus_a.out_ready = 1'b0;
        step();
        chk("t3_gnt", 32'(bus_a.gnt), 32'h4);
        chk("t3_sel", 32'({bus_a.S1, bus_a.S0}), 32'h2);
        step();
        chk("t3_vld", 32'(bus_a.out_valid), 32'h1);
        bus_a.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_vld_hold", 32'(bus_a.out_valid), 32'h1);
            chk("t3_y_hold",   32'(bus_a.Y), 32'h1);
        end
        bus_a.out_ready = 1'b1;
        step();
        chk("t3_vld_end", 32'(bus_a.out_valid), 32'h0);
        chk("t3_gnt_end", 32'(bus_a.gnt), 32'h0);
        chk("t3_ptr",     32'(u_a.ptr), 32'h3);
        step();
        chk("t3_idle_gnt", 32'(bus_a.gnt), 32'h0);
        chk("t3_idle_vld", 32'(bus_a.out_valid), 32'h0);

        // ---- wrap from ptr=3, no preemption (a) ----
        bus_a.req = 4'b1001; bus_a.I3 = 1'b1; bus_a.I0 = 1'b0;
        step();
        chk("t4_gnt3", 32'(bus_a.gnt), 32'h8);
        chk("t4_sel3", 32'({bus_a.S1, bus_a.S0}), 32'h3);
        step();
        chk("t4_vld", 32'(bus_a.out_valid), 32'h1);
        chk("t4_y3",  32'(bus_a.Y), 32'h1);
        bus_a.req = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_nopreempt", 32'(bus_a.gnt), 32'h8);
        end
        step();
        chk("t4_end_vld", 32'(bus_a.out_valid), 32'h0);
        chk("t4_ptr",     32'(u_a.ptr), 32'h0);
        step();
        chk("t4_wrap_gnt", 32'(bus_a.gnt), 32'h1);
        chk("t4_wrap_sel", 32'({bus_a.S1, bus_a.S0}), 32'h0);
        bus_a.req = 4'b0010;
        step();
        chk("t4_y0", 32'(bus_a.Y), 32'h0);
        step();
        chk("t4_drop_end", 32'(bus_a.out_valid), 32'h0);
        step();
        chk("t4_gnt1", 32'(bus_a.gnt), 32'h2);
        bus_a.req = 4'b0100;
        step();
        step();
        chk("t4_ptr2", 32'(u_a.ptr), 32'h2);
        step();
        chk("t4_gnt2", 32'(bus_a.gnt), 32'h4);
        step();
        chk("t4_vld2", 32'(bus_a.out_valid), 32'h1);
        chk("t4_sel2", 32'({bus_a.S1, bus_a.S0}), 32'h2);

        // ---- asynchronous reset mid-XFER (a) ----
        #2 rst = 1'b1;
        #1;
        chk("t5_vld", 32'(bus_a.out_valid), 32'h0);
        chk("t5_gnt", 32'(bus_a.gnt), 32'h0);
        chk("t5_sel", 32'({bus_a.S1, bus_a.S0}), 32'h0);
        chk("t5_y",   32'(bus_a.Y), 32'h0);
        step();
        rst = 1'b0;
        bus_a.req = 4'b0110;
        step();
        chk("t5_first_gnt", 32'(bus_a.gnt), 32'h2);
        chk("t5_first_sel", 32'({bus_a.S1, bus_a.S0}), 32'h1);
        bus_a.req = 4'b0000;
        bus_a.out_ready = 1'b0;

        // ---- 8-bit data, BURST=2 sequence (c) ----
        bus_c.I0 = dat_c[0]; bus_c.I1 = dat_c[1]; bus_c.I2 = dat_c[2]; bus_c.I3 = dat_c[3];
        bus_c.req = 4'b1111; bus_c.out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t6_gnt",    32'(bus_c.gnt), 32'h1 << n);
            chk("t6_y_idle", 32'(bus_c.Y), 32'h0);
            step();
            chk("t6_y_beat0", 32'(bus_c.Y), 32'(dat_c[n]));
            step();
            chk("t6_y_beat1", 32'(bus_c.Y), 32'(dat_c[n]));
            chk("t6_vld_beat1", 32'(bus_c.out_valid), 32'h1);
            step();
            chk("t6_vld_end", 32'(bus_c.out_valid), 32'h0);
            chk("t6_y_end",   32'(bus_c.Y), 32'h0);
        end
        bus_c.req = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
